arm_banked_regfile: RTL and testbench
=====================================

# arm_banked_regfile

Parametrised ARM7TDMI register file with mode banking. Provides 16 architecturally visible registers mapped onto 31 physical GPRs and 5 SPSRs, plus a full CPSR (NZCV, I, F, T, mode) and a hardware exception-entry sequence. Sits between decode (read addresses) and writeback/ALU (write ports, flags). It supersedes the flat 16×32 file and its 4-bit flag register.

## Interface
- DATA_W, 32: GPR/PSR data width.
- RESET_PC, 32'h0000_0000: R15 value after reset.
- VECTOR_BASE, 32'h0000_0000: exception vector base (high-vectors option).
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- rd_addr_a/b/c  in  4 each  architectural read addresses (Rn, Rm, Rs)
- rd_data_a/b/c  out  DATA_W each  read data, current-mode view
- wr_en_a, wr_addr_a[3:0], wr_data_a[DATA_W]  in  primary writeback port
- wr_en_b, wr_addr_b[3:0], wr_data_b[DATA_W]  in  secondary port (base writeback)
- pc_inc  in  1  advance R15 by 4 (ARM) or 2 (Thumb, CPSR.T=1)
- flags_we  in  1  load NZCV from flags_in
- flags_in  in  4  {N,Z,C,V}
- psr_we  in  1  write PSR under psr_mask
- psr_sel_spsr  in  1  0: target CPSR, 1: target current-mode SPSR
- psr_mask  in  2  bit1: flags byte [31:24], bit0: control byte [7:0]
- psr_wdata  in  DATA_W  PSR write data
- spsr_restore  in  1  CPSR ← SPSR_mode (exception return)
- exc_req  in  1  take exception this edge
- exc_type  in  3  RESET/UND/SWI/PABT/DABT/IRQ/FIQ
- exc_ret_addr  in  DATA_W  value loaded into banked LR
- cpsr, spsr  out  DATA_W  current CPSR; current-mode SPSR (0 in USR/SYS)
- pc  out  DATA_W  current R15

## Operation
- Modes: USR 10000, FIQ 10001, IRQ 10010, SVC 10011, ABT 10111, UND 11011, SYS 11111. USR/SYS share the user bank.
- Banking: FIQ banks R8–R14; IRQ/SVC/ABT/UND bank R13–R14; one SPSR per exception mode.
- Reads: combinational via mode map; R15 reads return pc (no pipeline offset added here).
- Writes: physical target resolved with mode in force before the edge. Same physical register on both ports: port A wins. Write to R15 overrides pc_inc.
- Flags: flags_we updates CPSR[31:28]; psr_we to CPSR flags byte in the same cycle overrides flags_we.
- psr_we control byte in USR mode: ignored. Mode field with an invalid encoding: whole control-byte write ignored. T bit is not writable via psr_we.
- Exception entry (exc_req=1), single edge: SPSR_new ← old CPSR; LR_new ← exc_ret_addr; mode ← target; T←0; I←1; F←1 for RESET/FIQ only; R15 ← VECTOR_BASE + {0x00,0x04,0x08,0x0C,0x10,0x18,0x1C}[type].
- exc_req priority: overrides psr_we, spsr_restore, flags_we, pc_inc and any R15 write; other GPR writes still commit (old-mode map), except when they target the new LR, which exc_req overrides.
- spsr_restore in USR/SYS: no effect.

## Timing
- Reset: all GPRs and SPSRs 0; CPSR = 0x0000_00D3 (SVC, I=F=1, T=0, NZCV=0); pc = RESET_PC.
- Read latency 0; write-to-read latency 1 (no bypass).
- Mode change takes effect for reads the cycle after the edge.
- Reset asserted mid-exception-entry: reset wins; no partial state.

## Structure
- Package arm_pkg: mode encodings, exception-type enum, vector offsets, CPSR bit positions, reset CPSR constant.
- Sub-module arm_bank_map: combinational (mode, arch addr) → 5-bit physical index and spsr index; instantiated once per read port and per write port.

## Test plan
- Reset, then read R0–R15 → all 0 except pc=RESET_PC; cpsr=0x0000_00D3.
- Switch SVC→FIQ via psr_we (mask=01, data 0x11); write R8=0xAAAA_5555; switch to USR → R8 reads 0; back to FIQ → 0xAAAA_5555.
- In USR, exc_req IRQ, exc_ret_addr=0x104 → mode IRQ, I=1, F unchanged, LR_irq=0x104, pc=0x18, spsr=old CPSR; spsr_restore → CPSR back to USR value.
- Ports A and B both write R3 (0x1, 0x2) → R3=0x1; port B writing R15=0x200 with pc_inc=1 → pc=0x200.
- flags_we=1, flags_in=4'b1010 with psr_we mask=10 data 0x6000_0000 same cycle → NZCV=0110.
- In USR, psr_we control byte 0x13 → mode unchanged; in SVC, write mode 10101 (invalid) → CPSR unchanged.

Source files
------------

// File: rtl/arm_banked_regfile_pkg.sv
// arm_pkg: shared definitions for the ARM7TDMI banked register file.
//   - processor mode encodings and exception-type enum
//   - CPSR bit positions and reset value
//   - physical GPR / SPSR slot layout used by the bank map
//   - helpers: mode validity, exception target mode, vector offset
package arm_pkg;

    typedef enum logic [4:0] {
        MODE_USR = 5'b10000,
        MODE_FIQ = 5'b10001,
        MODE_IRQ = 5'b10010,
        MODE_SVC = 5'b10011,
        MODE_ABT = 5'b10111,
        MODE_UND = 5'b11011,
        MODE_SYS = 5'b11111
    } mode_e;

    typedef enum logic [2:0] {
        EXC_RESET = 3'd0,
        EXC_UND   = 3'd1,
        EXC_SWI   = 3'd2,
        EXC_PABT  = 3'd3,
        EXC_DABT  = 3'd4,
        EXC_IRQ   = 3'd5,
        EXC_FIQ   = 3'd6
    } exc_e;

    localparam int unsigned CPSR_I = 7;
    localparam int unsigned CPSR_F = 6;
    localparam int unsigned CPSR_T = 5;
    localparam logic [31:0] CPSR_RESET = 32'h0000_00D3;

    // Physical layout: 0-14 user R0-R14, 15-21 FIQ R8-R14,
    // then R13/R14 pairs for IRQ, SVC, ABT, UND. Slot 30 is R15 (pc).
    localparam int unsigned NUM_GPR      = 30;
    localparam int unsigned NUM_SPSR     = 5;
    localparam logic [4:0]  PC_IDX       = 5'd30;
    localparam logic [4:0]  PHYS_FIQ_R8  = 5'd15;
    localparam logic [4:0]  PHYS_IRQ_R13 = 5'd22;
    localparam logic [4:0]  PHYS_SVC_R13 = 5'd24;
    localparam logic [4:0]  PHYS_ABT_R13 = 5'd26;
    localparam logic [4:0]  PHYS_UND_R13 = 5'd28;

    localparam logic [2:0] SPSR_FIQ = 3'd0;
    localparam logic [2:0] SPSR_IRQ = 3'd1;
    localparam logic [2:0] SPSR_SVC = 3'd2;
    localparam logic [2:0] SPSR_ABT = 3'd3;
    localparam logic [2:0] SPSR_UND = 3'd4;

    function automatic logic mode_is_valid(input logic [4:0] m);
        case (m)
            MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
            MODE_ABT, MODE_UND, MODE_SYS: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic [4:0] exc_target_mode(input logic [2:0] t);
        case (t)
            EXC_RESET, EXC_SWI:  return MODE_SVC;
            EXC_PABT, EXC_DABT:  return MODE_ABT;
            EXC_IRQ:             return MODE_IRQ;
            EXC_FIQ:             return MODE_FIQ;
            default:             return MODE_UND;
        endcase
    endfunction

    function automatic logic [7:0] vector_offset(input logic [2:0] t);
        case (t)
            EXC_RESET: return 8'h00;
            EXC_SWI:   return 8'h08;
            EXC_PABT:  return 8'h0C;
            EXC_DABT:  return 8'h10;
            EXC_IRQ:   return 8'h18;
            EXC_FIQ:   return 8'h1C;
            default:   return 8'h04;
        endcase
    endfunction

endpackage

// File: rtl/arm_banked_regfile_if.sv
// arm_banked_regfile_if: decode/writeback-side bus of the banked register file.
//   Reads : rd_addr_a/b/c -> rd_data_a/b/c (current-mode view)
//   Writes: ports A/B, pc_inc, flags, PSR write, SPSR restore
//   Except: exc_req/exc_type/exc_ret_addr
//   Status: cpsr, spsr, pc
// master = pipeline side, slave = register file.
interface arm_banked_regfile_if #(
    parameter int unsigned DATA_W = 32
);
    logic [3:0]        rd_addr_a, rd_addr_b, rd_addr_c;
    logic [DATA_W-1:0] rd_data_a, rd_data_b, rd_data_c;
    logic              wr_en_a, wr_en_b;
    logic [3:0]        wr_addr_a, wr_addr_b;
    logic [DATA_W-1:0] wr_data_a, wr_data_b;
    logic              pc_inc;
    logic              flags_we;
    logic [3:0]        flags_in;
    logic              psr_we;
    logic              psr_sel_spsr;
    logic [1:0]        psr_mask;
    logic [DATA_W-1:0] psr_wdata;
    logic              spsr_restore;
    logic              exc_req;
    logic [2:0]        exc_type;
    logic [DATA_W-1:0] exc_ret_addr;
    logic [DATA_W-1:0] cpsr, spsr, pc;

    modport master (
        output rd_addr_a, rd_addr_b, rd_addr_c,
        output wr_en_a, wr_addr_a, wr_data_a, wr_en_b, wr_addr_b, wr_data_b,
        output pc_inc, flags_we, flags_in,
        output psr_we, psr_sel_spsr, psr_mask, psr_wdata, spsr_restore,
        output exc_req, exc_type, exc_ret_addr,
        input  rd_data_a, rd_data_b, rd_data_c, cpsr, spsr, pc
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, rd_addr_c,
        input  wr_en_a, wr_addr_a, wr_data_a, wr_en_b, wr_addr_b, wr_data_b,
        input  pc_inc, flags_we, flags_in,
        input  psr_we, psr_sel_spsr, psr_mask, psr_wdata, spsr_restore,
        input  exc_req, exc_type, exc_ret_addr,
        output rd_data_a, rd_data_b, rd_data_c, cpsr, spsr, pc
    );
endinterface

// File: rtl/arm_banked_regfile_bank_map.sv
// arm_bank_map: combinational (mode, architectural register) -> physical slot.
//   mode_i       : CPSR mode field
//   addr_i       : architectural register number R0-R15
//   phys_o       : physical GPR slot (PC_IDX for R15)
//   spsr_idx_o   : SPSR slot of this mode
//   spsr_valid_o : mode owns an SPSR (0 for USR/SYS/invalid modes)
// Invalid mode encodings fall back to the user bank.
module arm_bank_map
    import arm_pkg::*;
(
    input  logic [4:0] mode_i,
    input  logic [3:0] addr_i,
    output logic [4:0] phys_o,
    output logic [2:0] spsr_idx_o,
    output logic       spsr_valid_o
);
    logic       hi_banked;
    logic [4:0] hi_base;

    always_comb begin
        phys_o       = {1'b0, addr_i};
        spsr_idx_o   = '0;
        spsr_valid_o = 1'b1;
        hi_banked    = 1'b0;
        hi_base      = '0;
        case (mode_i)
            MODE_FIQ: begin
                spsr_idx_o = SPSR_FIQ;
                if (addr_i[3] && addr_i != 4'd15)
                    phys_o = PHYS_FIQ_R8 + {2'b00, addr_i[2:0]};
            end
            MODE_IRQ: begin spsr_idx_o = SPSR_IRQ; hi_banked = 1'b1; hi_base = PHYS_IRQ_R13; end
            MODE_SVC: begin spsr_idx_o = SPSR_SVC; hi_banked = 1'b1; hi_base = PHYS_SVC_R13; end
            MODE_ABT: begin spsr_idx_o = SPSR_ABT; hi_banked = 1'b1; hi_base = PHYS_ABT_R13; end
            MODE_UND: begin spsr_idx_o = SPSR_UND; hi_banked = 1'b1; hi_base = PHYS_UND_R13; end
            default:  spsr_valid_o = 1'b0;
        endcase
        if (hi_banked && (addr_i == 4'd13 || addr_i == 4'd14))
            phys_o = hi_base + {4'b0000, addr_i == 4'd14};
        if (addr_i == 4'd15)
            phys_o = PC_IDX;
    end
endmodule

// File: rtl/arm_banked_regfile.sv
// arm_banked_regfile: ARM7TDMI register file with mode banking.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : three combinational read ports, two write ports,
//                  pc_inc, NZCV load, masked PSR write, SPSR restore,
//                  single-edge exception entry; cpsr/spsr/pc status.
// Write targets resolve through the mode in force before the edge.
module arm_banked_regfile
    import arm_pkg::*;
#(
    parameter int unsigned       DATA_W      = 32,
    parameter logic [DATA_W-1:0] RESET_PC    = '0,
    parameter logic [DATA_W-1:0] VECTOR_BASE = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    arm_banked_regfile_if.slave  bus
);
    logic [DATA_W-1:0] gpr_q  [NUM_GPR];
    logic [DATA_W-1:0] gpr_d  [NUM_GPR];
    logic [DATA_W-1:0] spsr_q [NUM_SPSR];
    logic [DATA_W-1:0] spsr_d [NUM_SPSR];
    logic [DATA_W-1:0] cpsr_q, cpsr_d, pc_q, pc_d;

    logic [4:0] mode, new_mode;
    logic [4:0] phys_ra, phys_rb, phys_rc, phys_wa, phys_wb, phys_lr;
    logic [2:0] spsr_idx_cur, spsr_idx_new;
    logic       spsr_valid_cur;
    logic [2:0] unused_sidx_rb, unused_sidx_rc, unused_sidx_wa, unused_sidx_wb;
    logic       unused_sv_rb, unused_sv_rc, unused_sv_wa, unused_sv_wb, unused_sv_lr;
    logic       unused_wdata;

    assign mode     = cpsr_q[4:0];
    assign new_mode = exc_target_mode(bus.exc_type);
    assign unused_wdata = ^{bus.psr_wdata[DATA_W-9:8], bus.psr_wdata[CPSR_T]};

    arm_bank_map u_map_ra (.mode_i(mode), .addr_i(bus.rd_addr_a), .phys_o(phys_ra),
                           .spsr_idx_o(spsr_idx_cur), .spsr_valid_o(spsr_valid_cur));
    arm_bank_map u_map_rb (.mode_i(mode), .addr_i(bus.rd_addr_b), .phys_o(phys_rb),
                           .spsr_idx_o(unused_sidx_rb), .spsr_valid_o(unused_sv_rb));
    arm_bank_map u_map_rc (.mode_i(mode), .addr_i(bus.rd_addr_c), .phys_o(phys_rc),
                           .spsr_idx_o(unused_sidx_rc), .spsr_valid_o(unused_sv_rc));
    arm_bank_map u_map_wa (.mode_i(mode), .addr_i(bus.wr_addr_a), .phys_o(phys_wa),
                           .spsr_idx_o(unused_sidx_wa), .spsr_valid_o(unused_sv_wa));
    arm_bank_map u_map_wb (.mode_i(mode), .addr_i(bus.wr_addr_b), .phys_o(phys_wb),
                           .spsr_idx_o(unused_sidx_wb), .spsr_valid_o(unused_sv_wb));
    // Banked LR and SPSR of the mode an exception would enter.
    arm_bank_map u_map_lr (.mode_i(new_mode), .addr_i(4'd14), .phys_o(phys_lr),
                           .spsr_idx_o(spsr_idx_new), .spsr_valid_o(unused_sv_lr));

    assign bus.rd_data_a = (phys_ra == PC_IDX) ? pc_q : gpr_q[phys_ra];
    assign bus.rd_data_b = (phys_rb == PC_IDX) ? pc_q : gpr_q[phys_rb];
    assign bus.rd_data_c = (phys_rc == PC_IDX) ? pc_q : gpr_q[phys_rc];
    assign bus.cpsr      = cpsr_q;
    assign bus.spsr      = spsr_valid_cur ? spsr_q[spsr_idx_cur] : '0;
    assign bus.pc        = pc_q;

    always_comb begin
        gpr_d  = gpr_q;
        spsr_d = spsr_q;
        cpsr_d = cpsr_q;
        pc_d   = pc_q;

        // Port B first so port A wins on a shared physical target;
        // an exception's LR load beats both.
        if (bus.wr_en_b && phys_wb != PC_IDX && !(bus.exc_req && phys_wb == phys_lr))
            gpr_d[phys_wb] = bus.wr_data_b;
        if (bus.wr_en_a && phys_wa != PC_IDX && !(bus.exc_req && phys_wa == phys_lr))
            gpr_d[phys_wa] = bus.wr_data_a;

        if (bus.exc_req) begin
            gpr_d[phys_lr]       = bus.exc_ret_addr;
            spsr_d[spsr_idx_new] = cpsr_q;
            cpsr_d[4:0]          = new_mode;
            cpsr_d[CPSR_T]       = 1'b0;
            cpsr_d[CPSR_I]       = 1'b1;
            if (bus.exc_type == EXC_RESET || bus.exc_type == EXC_FIQ)
                cpsr_d[CPSR_F] = 1'b1;
            pc_d = VECTOR_BASE + {{(DATA_W-8){1'b0}}, vector_offset(bus.exc_type)};
        end else begin
            if (bus.wr_en_a && phys_wa == PC_IDX)
                pc_d = bus.wr_data_a;
            else if (bus.wr_en_b && phys_wb == PC_IDX)
                pc_d = bus.wr_data_b;
            else if (bus.pc_inc)
                pc_d = pc_q + (cpsr_q[CPSR_T] ? DATA_W'(2) : DATA_W'(4));

            if (bus.psr_we && bus.psr_sel_spsr && spsr_valid_cur) begin
                if (bus.psr_mask[1])
                    spsr_d[spsr_idx_cur][DATA_W-1 -: 8] = bus.psr_wdata[DATA_W-1 -: 8];
                if (bus.psr_mask[0])
                    spsr_d[spsr_idx_cur][7:0] = bus.psr_wdata[7:0];
            end

            if (bus.spsr_restore && spsr_valid_cur) begin
                cpsr_d = spsr_q[spsr_idx_cur];
            end else begin
                if (bus.flags_we)
                    cpsr_d[DATA_W-1 -: 4] = bus.flags_in;
                if (bus.psr_we && !bus.psr_sel_spsr) begin
                    if (bus.psr_mask[1])
                        cpsr_d[DATA_W-1 -: 8] = bus.psr_wdata[DATA_W-1 -: 8];
                    // Control byte: privileged modes only, valid mode only, T preserved.
                    if (bus.psr_mask[0] && mode != MODE_USR && mode_is_valid(bus.psr_wdata[4:0])) begin
                        cpsr_d[CPSR_I] = bus.psr_wdata[CPSR_I];
                        cpsr_d[CPSR_F] = bus.psr_wdata[CPSR_F];
                        cpsr_d[4:0]    = bus.psr_wdata[4:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_GPR; i++)  gpr_q[i]  <= '0;
            for (int unsigned i = 0; i < NUM_SPSR; i++) spsr_q[i] <= '0;
            cpsr_q <= DATA_W'(CPSR_RESET);
            pc_q   <= RESET_PC;
        end else begin
            gpr_q  <= gpr_d;
            spsr_q <= spsr_d;
            cpsr_q <= cpsr_d;
            pc_q   <= pc_d;
        end
    end
endmodule

// File: tb/tb_arm_banked_regfile.sv
// Testbench for arm_banked_regfile: directed scenarios with literal
// expectations, then randomized traffic against a bank-by-mode model.
module tb_arm_banked_regfile;
    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam logic [31:0] VB     = 32'h0000_0000;
    localparam logic [4:0]  TGT_MODE [7] = '{5'b10011, 5'b11011, 5'b10011, 5'b10111,
                                             5'b10111, 5'b10010, 5'b10001};
    localparam logic [31:0] VEC_OFF  [7] = '{32'h00, 32'h04, 32'h08, 32'h0C,
                                             32'h10, 32'h18, 32'h1C};
    localparam logic [4:0]  MODES    [7] = '{5'b10000, 5'b10001, 5'b10010, 5'b10011,
                                             5'b10111, 5'b11011, 5'b11111};

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    arm_banked_regfile_if #(.DATA_W(32)) bus ();

    arm_banked_regfile #(.DATA_W(32), .RESET_PC(RST_PC), .VECTOR_BASE(VB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model: bank 0 = user, 1 = FIQ, 2..5 = IRQ/SVC/ABT/UND.
    logic [31:0] m_gpr  [6][15];
    logic [31:0] m_spsr [6];
    logic [31:0] m_cpsr, m_pc;

    function automatic int bank_of(input logic [4:0] m);
        case (m)
            5'b10001: return 1;
            5'b10010: return 2;
            5'b10011: return 3;
            5'b10111: return 4;
            5'b11011: return 5;
            default:  return 0;
        endcase
    endfunction

    function automatic int home_bank(input int b, input int r);
        if (b == 1 && r >= 8) return 1;
        if (b >= 2 && r >= 13) return b;
        return 0;
    endfunction

    function automatic logic mode_ok(input logic [4:0] m);
        for (int i = 0; i < 7; i++) if (MODES[i] == m) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] r);
        int ri = int'(r);
        if (ri == 15) return m_pc;
        return m_gpr[home_bank(bank_of(m_cpsr[4:0]), ri)][ri];
    endfunction

    function automatic logic [31:0] m_spsr_view();
        int b = bank_of(m_cpsr[4:0]);
        return (b == 0) ? 32'h0 : m_spsr[b];
    endfunction

    task automatic model_step();
        int ob, nb, lrb, t, ra, rb;
        logic [4:0]  tmode;
        logic [31:0] ncpsr, npc, old_spsr;
        if (reset) begin
            for (int b = 0; b < 6; b++) begin
                for (int r = 0; r < 15; r++) m_gpr[b][r] = '0;
                m_spsr[b] = '0;
            end
            m_cpsr = 32'h0000_00D3;
            m_pc   = RST_PC;
            return;
        end
        ob    = bank_of(m_cpsr[4:0]);
        t     = int'(bus.exc_type);
        tmode = TGT_MODE[t];
        nb    = bank_of(tmode);
        lrb   = home_bank(nb, 14);
        ra    = int'(bus.wr_addr_a);
        rb    = int'(bus.wr_addr_b);
        ncpsr = m_cpsr;
        npc   = m_pc;
        old_spsr = m_spsr[ob];

        if (bus.wr_en_b && rb != 15 && !(bus.exc_req && rb == 14 && home_bank(ob, rb) == lrb))
            m_gpr[home_bank(ob, rb)][rb] = bus.wr_data_b;
        if (bus.wr_en_a && ra != 15 && !(bus.exc_req && ra == 14 && home_bank(ob, ra) == lrb))
            m_gpr[home_bank(ob, ra)][ra] = bus.wr_data_a;

        if (bus.exc_req) begin
            m_gpr[lrb][14] = bus.exc_ret_addr;
            m_spsr[nb]     = m_cpsr;
            ncpsr[4:0]     = tmode;
            ncpsr[5]       = 1'b0;
            ncpsr[7]       = 1'b1;
            if (t == 0 || t == 6) ncpsr[6] = 1'b1;
            npc = VB + VEC_OFF[t];
        end else begin
            if (bus.wr_en_a && ra == 15)      npc = bus.wr_data_a;
            else if (bus.wr_en_b && rb == 15) npc = bus.wr_data_b;
            else if (bus.pc_inc)              npc = m_pc + (m_cpsr[5] ? 32'd2 : 32'd4);

            if (bus.psr_we && bus.psr_sel_spsr && ob != 0) begin
                if (bus.psr_mask[1]) m_spsr[ob][31:24] = bus.psr_wdata[31:24];
                if (bus.psr_mask[0]) m_spsr[ob][7:0]   = bus.psr_wdata[7:0];
            end
            if (bus.spsr_restore && ob != 0) begin
                ncpsr = old_spsr;
            end else begin
                if (bus.flags_we) ncpsr[31:28] = bus.flags_in;
                if (bus.psr_we && !bus.psr_sel_spsr) begin
                    if (bus.psr_mask[1]) ncpsr[31:24] = bus.psr_wdata[31:24];
                    if (bus.psr_mask[0] && m_cpsr[4:0] != 5'b10000 && mode_ok(bus.psr_wdata[4:0])) begin
                        ncpsr[7:6] = bus.psr_wdata[7:6];
                        ncpsr[4:0] = bus.psr_wdata[4:0];
                    end
                end
            end
        end
        m_cpsr = ncpsr;
        m_pc   = npc;
    endtask

    task automatic idle();
        bus.rd_addr_a = '0; bus.rd_addr_b = '0; bus.rd_addr_c = '0;
        bus.wr_en_a = 1'b0; bus.wr_addr_a = '0; bus.wr_data_a = '0;
        bus.wr_en_b = 1'b0; bus.wr_addr_b = '0; bus.wr_data_b = '0;
        bus.pc_inc = 1'b0; bus.flags_we = 1'b0; bus.flags_in = '0;
        bus.psr_we = 1'b0; bus.psr_sel_spsr = 1'b0; bus.psr_mask = '0; bus.psr_wdata = '0;
        bus.spsr_restore = 1'b0;
        bus.exc_req = 1'b0; bus.exc_type = '0; bus.exc_ret_addr = '0;
    endtask

    // Reads checked before the edge; state checked just after it.
    task automatic tick();
        #1;
        check("rd_a", bus.rd_data_a, m_read(bus.rd_addr_a));
        check("rd_b", bus.rd_data_b, m_read(bus.rd_addr_b));
        check("rd_c", bus.rd_data_c, m_read(bus.rd_addr_c));
        @(posedge clock);
        model_step();
        #1;
        check("cpsr", bus.cpsr, m_cpsr);
        check("spsr", bus.spsr, m_spsr_view());
        check("pc", bus.pc, m_pc);
    endtask

    task automatic rd(input logic [3:0] r, input logic [31:0] exp, input string tag);
        bus.rd_addr_a = r;
        #1;
        check(tag, bus.rd_data_a, exp);
    endtask

    task automatic psr_ctrl(input logic [31:0] data);
        bus.psr_we = 1'b1; bus.psr_mask = 2'b01; bus.psr_wdata = data;
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clock);
        model_step();
        #1;
        tick();
        reset = 1'b0;

        check("rst_cpsr", bus.cpsr, 32'h0000_00D3);
        check("rst_pc", bus.pc, RST_PC);
        check("rst_spsr", bus.spsr, 32'h0);
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), (i == 15) ? RST_PC : 32'h0, "rst_reg");
            tick();
        end

        // FIQ banking of R8
        psr_ctrl(32'h11);
        check("fiq_cpsr", bus.cpsr, 32'h0000_0011);
        bus.wr_en_a = 1'b1; bus.wr_addr_a = 4'd8; bus.wr_data_a = 32'hAAAA_5555;
        tick(); idle();
        psr_ctrl(32'h1F);
        rd(4'd8, 32'h0, "sys_r8");
        psr_ctrl(32'h11);
        rd(4'd8, 32'hAAAA_5555, "fiq_r8");
        psr_ctrl(32'h10);
        check("usr_cpsr", bus.cpsr, 32'h0000_0010);
        rd(4'd8, 32'h0, "usr_r8");

        // IRQ entry from USR and return
        bus.flags_we = 1'b1; bus.flags_in = 4'b1001;
        tick(); idle();
        bus.exc_req = 1'b1; bus.exc_type = 3'd5; bus.exc_ret_addr = 32'h104;
        tick(); idle();
        check("irq_cpsr", bus.cpsr, 32'h9000_0092);
        check("irq_spsr", bus.spsr, 32'h9000_0010);
        check("irq_pc", bus.pc, 32'h18);
        rd(4'd14, 32'h104, "irq_lr");
        bus.spsr_restore = 1'b1;
        tick(); idle();
        check("ret_cpsr", bus.cpsr, 32'h9000_0010);
        rd(4'd14, 32'h0, "usr_lr");

        // Write-port collisions
        bus.wr_en_a = 1'b1; bus.wr_addr_a = 4'd3; bus.wr_data_a = 32'h1;
        bus.wr_en_b = 1'b1; bus.wr_addr_b = 4'd3; bus.wr_data_b = 32'h2;
        tick(); idle();
        rd(4'd3, 32'h1, "r3_port_a_wins");
        bus.wr_en_b = 1'b1; bus.wr_addr_b = 4'd15; bus.wr_data_b = 32'h200; bus.pc_inc = 1'b1;
        tick(); idle();
        check("pc_write_over_inc", bus.pc, 32'h200);
        bus.pc_inc = 1'b1;
        tick(); idle();
        check("pc_inc_arm", bus.pc, 32'h204);

        // PSR write rules
        psr_ctrl(32'h13);
        check("usr_ctrl_ignored", bus.cpsr, 32'h9000_0010);
        bus.flags_we = 1'b1; bus.flags_in = 4'b1010;
        bus.psr_we = 1'b1; bus.psr_mask = 2'b10; bus.psr_wdata = 32'h6000_0000;
        tick(); idle();
        check("psr_over_flags", bus.cpsr, 32'h6000_0010);
        bus.exc_req = 1'b1; bus.exc_type = 3'd2; bus.exc_ret_addr = 32'h208;
        tick(); idle();
        check("swi_cpsr", bus.cpsr, 32'h6000_0093);
        check("swi_spsr", bus.spsr, 32'h6000_0010);
        check("swi_pc", bus.pc, 32'h08);
        psr_ctrl(32'h15);
        check("bad_mode_ignored", bus.cpsr, 32'h6000_0093);
        psr_ctrl(32'h3F);
        check("t_not_writable", bus.cpsr, 32'h6000_001F);

        // Reset beats a simultaneous exception
        reset = 1'b1; bus.exc_req = 1'b1; bus.exc_type = 3'd6; bus.exc_ret_addr = 32'hDEAD;
        tick();
        reset = 1'b0; idle();
        check("rst_exc_cpsr", bus.cpsr, 32'h0000_00D3);
        check("rst_exc_pc", bus.pc, RST_PC);
        check("rst_exc_spsr", bus.spsr, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            bus.rd_addr_a = 4'($urandom); bus.rd_addr_b = 4'($urandom); bus.rd_addr_c = 4'($urandom);
            bus.wr_en_a = 1'($urandom); bus.wr_addr_a = 4'($urandom); bus.wr_data_a = $urandom;
            bus.wr_en_b = 1'($urandom); bus.wr_addr_b = 4'($urandom); bus.wr_data_b = $urandom;
            bus.pc_inc = 1'($urandom);
            bus.flags_we = ($urandom_range(0, 3) == 0); bus.flags_in = 4'($urandom);
            bus.psr_we = ($urandom_range(0, 5) == 0);
            bus.psr_sel_spsr = 1'($urandom); bus.psr_mask = 2'($urandom);
            bus.psr_wdata = $urandom;
            if ($urandom_range(0, 7) != 0)
                bus.psr_wdata[4:0] = MODES[$urandom_range(0, 6)];
            bus.spsr_restore = !bus.psr_we && !bus.flags_we && ($urandom_range(0, 11) == 0);
            bus.exc_req = ($urandom_range(0, 15) == 0);
            bus.exc_type = 3'($urandom_range(0, 6));
            bus.exc_ret_addr = $urandom;
            tick();
        end
        reset = 1'b0;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
